matmul_sequencer: RTL and testbench

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

---
 rtl/matmul_pkg.sv | 25 ++
 rtl/matmul_mac.sv | 51 +++++
 rtl/matmul_sequencer.sv | 132 +++++++++++++
 tb/tb_matmul_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply sequencer.
// The saturation limit helpers are used by matmul_mac when MATMUL_SATURATE_EN is defined.
package matmul_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W     = 8;
  localparam int LIMIT_W    = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WRITE
  } state_t;

  // Signed range limits for a w-bit value, sign-extended to LIMIT_W bits (w <= 32).
  function automatic logic signed [LIMIT_W-1:0] sat_max(input int w);
    return (LIMIT_W'(1) << (w - 1)) - LIMIT_W'(1);
  endfunction

  function automatic logic signed [LIMIT_W-1:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Signed multiply-accumulate register for one result element.
// Define MATMUL_SATURATE_EN to clamp to the signed range instead of wrapping.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] acc
);

  logic signed [DATA_W-1:0] acc_next;

`ifdef MATMUL_SATURATE_EN
  localparam logic signed [2*DATA_W-1:0] PROD_MAX = (2*DATA_W)'(sat_max(DATA_W));
  localparam logic signed [2*DATA_W-1:0] PROD_MIN = (2*DATA_W)'(sat_min(DATA_W));

  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0]   prod_sat;
  logic signed [DATA_W:0]     sum;

  assign prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);

  // The full product is clamped first, then the one-bit-wider sum is clamped on overflow.
  always_comb begin
    if (prod > PROD_MAX)      prod_sat = PROD_MAX[DATA_W-1:0];
    else if (prod < PROD_MIN) prod_sat = PROD_MIN[DATA_W-1:0];
    else                      prod_sat = prod[DATA_W-1:0];
    sum = (DATA_W+1)'(acc) + (DATA_W+1)'(prod_sat);
    if (sum[DATA_W] != sum[DATA_W-1])
      acc_next = sum[DATA_W] ? PROD_MIN[DATA_W-1:0] : PROD_MAX[DATA_W-1:0];
    else
      acc_next = sum[DATA_W-1:0];
  end
`else
  assign acc_next = acc + a * b;
`endif

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     acc <= '0;
    else if (clear)  acc <= '0;
    else if (enable) acc <= acc_next;
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Streams A*B through one MAC: addresses operands, accumulates, writes each result.
// MATMUL_SATURATE_EN selects saturating accumulation inside matmul_mac.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int MAT1_HEIGHT = 2,
  parameter int MAT1_WIDTH  = 2,
  parameter int MAT2_WIDTH  = 2,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        a_addr,
  input  logic signed [DATA_W-1:0] a_data,
  output logic [ADDR_W-1:0]        b_addr,
  input  logic signed [DATA_W-1:0] b_data,
  output logic                     res_valid,
  output logic [ADDR_W-1:0]        res_addr,
  output logic signed [DATA_W-1:0] res_data
);

  localparam logic [ADDR_W-1:0] H1     = ADDR_W'(MAT1_HEIGHT);
  localparam logic [ADDR_W-1:0] W1     = ADDR_W'(MAT1_WIDTH);
  localparam logic [ADDR_W-1:0] W2     = ADDR_W'(MAT2_WIDTH);
  localparam logic [ADDR_W-1:0] B_BASE = ADDR_W'(MAT1_HEIGHT * MAT1_WIDTH);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_W-1:0]        a_addr_q, b_addr_q, res_addr_q;
  logic signed [DATA_W-1:0] res_data_q, acc;
  logic                     done_q, done_d, issued_q, clear, last_elem;

  assign last_elem = (i_q == H1 - ONE) && (j_q == W2 - ONE);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    clear   = 1'b0;
    done_d  = 1'b0;
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      clear   = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = ISSUE;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          clear   = 1'b1;
        end
        ISSUE: begin
          k_d = k_q + ONE;
          if (k_q == W1 - ONE) state_d = DRAIN;
        end
        DRAIN: state_d = WRITE;
        WRITE: begin
          clear = 1'b1;
          k_d   = '0;
          if (last_elem) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
            if (j_q == W2 - ONE) begin
              j_d = '0;
              i_d = i_q + ONE;
            end else begin
              j_d = j_q + ONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Addresses and results are live only in their own state and hold the last value otherwise.
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign res_valid = (state_q == WRITE) && !abort;
  assign a_addr    = (state_q == ISSUE) ? i_q * W1 + k_q : a_addr_q;
  assign b_addr    = (state_q == ISSUE) ? B_BASE + k_q * W2 + j_q : b_addr_q;
  assign res_addr  = res_valid ? i_q * W2 + j_q : res_addr_q;
  assign res_data  = res_valid ? acc : res_data_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      res_addr_q <= '0;
      res_data_q <= '0;
      done_q     <= 1'b0;
      issued_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      a_addr_q   <= a_addr;
      b_addr_q   <= b_addr;
      res_addr_q <= res_addr;
      res_data_q <= res_data;
      done_q     <= done_d;
      issued_q   <= (state_q == ISSUE);
    end
  end

  // Operand data arrives one cycle after its ISSUE, so the add is delayed by one cycle.
  matmul_mac #(.DATA_W(DATA_W)) u_mac (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear),
    .enable (issued_q && (state_q != IDLE)),
    .a      (a_data),
    .b      (b_data),
    .acc    (acc)
  );

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: 2x2x2, 3x2x1 and 1x1x1 instances against a reference model.
// Build with MATMUL_SATURATE_EN defined to check the saturating variant.
module tb_matmul_sequencer;

  localparam int DW = 32;
  typedef struct { int addr; int data; } res_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required end before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic, then clamp or wrap to 32 bits.
  function automatic int ref_mac(input int acc, input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
`ifdef MATMUL_SATURATE_EN
    if (p > 64'sd2147483647)  p = 64'sd2147483647;
    if (p < -64'sd2147483648) p = -64'sd2147483648;
    p = p + longint'(acc);
    if (p > 64'sd2147483647)  p = 64'sd2147483647;
    if (p < -64'sd2147483648) p = -64'sd2147483648;
    return int'(p);
`else
    return int'(longint'(acc) + p);
`endif
  endfunction

  function automatic void ref_matmul(input int h, input int w1, input int w2,
                                     input int mem[256], output int res[16]);
    for (int n = 0; n < 16; n++) res[n] = 0;
    for (int i = 0; i < h; i++)
      for (int j = 0; j < w2; j++)
        for (int k = 0; k < w1; k++)
          res[i*w2+j] = ref_mac(res[i*w2+j], mem[i*w1+k], mem[h*w1+k*w2+j]);
  endfunction

  function automatic int rand_operand();
    case ($urandom_range(0, 3))
      0:       return 32'sh7FFFFFFF;
      1:       return $signed($urandom);
      2:       return int'($urandom_range(0, 100)) - 50;
      default: return $signed($urandom) >>> 12;
    endcase
  endfunction

  // ---------------- main instance: 2x2x2 ----------------
  logic              m_start = 1'b0, m_abort = 1'b0;
  logic              m_busy, m_done, m_res_valid;
  logic [7:0]        m_a_addr, m_b_addr, m_res_addr;
  logic [DW-1:0]     m_a_data, m_b_data, m_res_data;
  int                m_mem[256];
  res_t              m_exp[$];
  int unsigned       m_done_exp[$];
  int                m_seen_res = 0, m_seen_done = 0;

  matmul_sequencer #(.MAT1_HEIGHT(2), .MAT1_WIDTH(2), .MAT2_WIDTH(2), .DATA_W(DW)) u_main (
    .clk(clk), .resetn(resetn), .start(m_start), .abort(m_abort), .busy(m_busy), .done(m_done),
    .a_addr(m_a_addr), .a_data(m_a_data), .b_addr(m_b_addr), .b_data(m_b_data),
    .res_valid(m_res_valid), .res_addr(m_res_addr), .res_data(m_res_data));

  always @(posedge clk) begin
    m_a_data <= m_mem[m_a_addr];
    m_b_data <= m_mem[m_b_addr];
  end

  always @(negedge clk) begin : mon_main
    res_t e;
    if (resetn) begin
      if (m_res_valid) begin
        m_seen_res++;
        check("main_res_expected", 32'(m_exp.size() != 0), 1);
        if (m_exp.size() != 0) begin
          e = m_exp.pop_front();
          check("main_res_addr", m_res_addr, e.addr);
          check("main_res_data", m_res_data, e.data);
        end
      end
      if (m_done) begin
        m_seen_done++;
        check("main_done_expected", 32'(m_done_exp.size() != 0), 1);
        if (m_done_exp.size() != 0) check("main_done_cycle", cyc, m_done_exp.pop_front());
      end
    end
  end

  // ---------------- tall instance: 3x2x1 ----------------
  logic              t_start = 1'b0, t_busy, t_done, t_res_valid;
  logic [7:0]        t_a_addr, t_b_addr, t_res_addr;
  logic [DW-1:0]     t_a_data, t_b_data, t_res_data;
  int                t_mem[256];
  res_t              t_exp[$];
  int unsigned       t_done_exp[$];
  int                t_seen_done = 0;

  matmul_sequencer #(.MAT1_HEIGHT(3), .MAT1_WIDTH(2), .MAT2_WIDTH(1), .DATA_W(DW)) u_tall (
    .clk(clk), .resetn(resetn), .start(t_start), .abort(1'b0), .busy(t_busy), .done(t_done),
    .a_addr(t_a_addr), .a_data(t_a_data), .b_addr(t_b_addr), .b_data(t_b_data),
    .res_valid(t_res_valid), .res_addr(t_res_addr), .res_data(t_res_data));

  always @(posedge clk) begin
    t_a_data <= t_mem[t_a_addr];
    t_b_data <= t_mem[t_b_addr];
  end

  always @(negedge clk) begin : mon_tall
    res_t e;
    if (resetn) begin
      if (t_res_valid) begin
        check("tall_res_expected", 32'(t_exp.size() != 0), 1);
        if (t_exp.size() != 0) begin
          e = t_exp.pop_front();
          check("tall_res_addr", t_res_addr, e.addr);
          check("tall_res_data", t_res_data, e.data);
        end
      end
      if (t_done) begin
        t_seen_done++;
        check("tall_done_expected", 32'(t_done_exp.size() != 0), 1);
        if (t_done_exp.size() != 0) check("tall_done_cycle", cyc, t_done_exp.pop_front());
      end
    end
  end

  // ---------------- unit instance: 1x1x1 ----------------
  logic              u_start = 1'b0, u_busy, u_done, u_res_valid;
  logic [7:0]        u_a_addr, u_b_addr, u_res_addr;
  logic [DW-1:0]     u_a_data, u_b_data, u_res_data;
  int                u_mem[256];
  res_t              u_exp[$];
  int unsigned       u_done_exp[$];
  int                u_seen_done = 0;

  matmul_sequencer #(.MAT1_HEIGHT(1), .MAT1_WIDTH(1), .MAT2_WIDTH(1), .DATA_W(DW)) u_unit (
    .clk(clk), .resetn(resetn), .start(u_start), .abort(1'b0), .busy(u_busy), .done(u_done),
    .a_addr(u_a_addr), .a_data(u_a_data), .b_addr(u_b_addr), .b_data(u_b_data),
    .res_valid(u_res_valid), .res_addr(u_res_addr), .res_data(u_res_data));

  always @(posedge clk) begin
    u_a_data <= u_mem[u_a_addr];
    u_b_data <= u_mem[u_b_addr];
  end

  always @(negedge clk) begin : mon_unit
    res_t e;
    if (resetn) begin
      if (u_res_valid) begin
        check("unit_res_expected", 32'(u_exp.size() != 0), 1);
        if (u_exp.size() != 0) begin
          e = u_exp.pop_front();
          check("unit_res_addr", u_res_addr, e.addr);
          check("unit_res_data", u_res_data, e.data);
        end
      end
      if (u_done) begin
        u_seen_done++;
        check("unit_done_expected", 32'(u_done_exp.size() != 0), 1);
        if (u_done_exp.size() != 0) check("unit_done_cycle", cyc, u_done_exp.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_res(input int n, input int res[16], input int which);
    res_t r;
    for (int e = 0; e < n; e++) begin
      r.addr = e;
      r.data = res[e];
      case (which)
        0:       m_exp.push_back(r);
        1:       t_exp.push_back(r);
        default: u_exp.push_back(r);
      endcase
    end
  endtask

  task automatic load_main(input int a0, a1, a2, a3, b0, b1, b2, b3);
    m_mem[0] = a0; m_mem[1] = a1; m_mem[2] = a2; m_mem[3] = a3;
    m_mem[4] = b0; m_mem[5] = b1; m_mem[6] = b2; m_mem[7] = b3;
  endtask

  // Start is raised for one cycle; done is due 17 cycles after that cycle.
  task automatic main_start(input bit with_abort);
    @(posedge clk); #1;
    m_start = 1'b1;
    m_abort = with_abort;
    @(negedge clk);
    m_done_exp.push_back(cyc + 17);
    @(posedge clk); #1;
    m_start = 1'b0;
    m_abort = 1'b0;
    @(negedge clk);
    check("main_busy_after_start", m_busy, 1);
  endtask

  task automatic main_run(input bit storm, input bit with_abort);
    int target;
    target = m_seen_done + 1;
    main_start(with_abort);
    for (int c = 2; c <= 16; c++) begin
      @(posedge clk); #1;
      m_start = storm ? 1'b1 : 1'($urandom_range(0, 3) == 0);
    end
    @(posedge clk); #1;
    m_start = 1'b0;
    for (int c = 0; c < 10 && m_seen_done < target; c++) begin
      @(negedge clk); #1;
    end
    check("main_done_seen", 32'(m_seen_done >= target), 1);
    check("main_queue_drained", m_exp.size(), 0);
  endtask

  task automatic main_wait_results(input int target);
    for (int c = 0; c < 40 && m_seen_res < target; c++) begin
      @(negedge clk); #1;
    end
    check("main_results_before_abort", 32'(m_seen_res >= target), 1);
  endtask

  task automatic main_abort_now();
    m_abort = 1'b1;
    @(posedge clk); #1;
    m_abort = 1'b0;
    m_exp.delete();
    m_done_exp.delete();
    @(negedge clk);
    check("main_busy_after_abort", m_busy, 0);
    repeat (20) @(negedge clk);
  endtask

  task automatic tall_run();
    int target;
    target = t_seen_done + 1;
    @(posedge clk); #1;
    t_start = 1'b1;
    @(negedge clk);
    t_done_exp.push_back(cyc + 13);
    @(posedge clk); #1;
    t_start = 1'b0;
    // Operand addresses per element: a = 2e+k, b = 6+k; held through DRAIN and WRITE.
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check("tall_a_addr", t_a_addr, ((c - 1) / 4) * 2 + (((c - 1) % 4) == 0 ? 0 : 1));
      check("tall_b_addr", t_b_addr, 6 + (((c - 1) % 4) == 0 ? 0 : 1));
    end
    for (int c = 0; c < 10 && t_seen_done < target; c++) begin
      @(negedge clk); #1;
    end
    check("tall_done_seen", 32'(t_seen_done >= target), 1);
    check("tall_queue_drained", t_exp.size(), 0);
  endtask

  task automatic unit_run();
    int target;
    target = u_seen_done + 1;
    @(posedge clk); #1;
    u_start = 1'b1;
    @(negedge clk);
    u_done_exp.push_back(cyc + 4);
    @(posedge clk); #1;
    u_start = 1'b0;
    for (int c = 0; c < 10 && u_seen_done < target; c++) begin
      @(negedge clk); #1;
    end
    check("unit_done_seen", 32'(u_seen_done >= target), 1);
    check("unit_queue_drained", u_exp.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  int res[16];
  int lit[16];

  initial begin
    @(negedge clk);
    check("reset_main_ctrl", {m_busy, m_done, m_res_valid, m_a_addr, m_b_addr, m_res_addr}, 0);
    check("reset_main_data", m_res_data, 0);
    check("reset_tall_ctrl", {t_busy, t_done, t_res_valid, t_a_addr, t_b_addr, t_res_addr}, 0);
    check("reset_unit_ctrl", {u_busy, u_done, u_res_valid, u_a_addr, u_b_addr, u_res_addr}, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Directed product with hand-computed results.
    lit = '{19, 22, 43, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    load_main(1, 2, 3, 4, 5, 6, 7, 8);
    push_res(4, lit, 0);
    main_run(1'b0, 1'b0);

    // Start held high for the whole job must not restart it.
    push_res(4, lit, 0);
    main_run(1'b1, 1'b0);

    // Abort in IDLE together with start: start still accepted.
    push_res(4, lit, 0);
    main_run(1'b0, 1'b1);

    // Abort right after the second result, then a clean rerun.
    push_res(4, lit, 0);
    main_start(1'b0);
    main_wait_results(m_seen_res + 2);
    @(posedge clk); #1;
    main_abort_now();
    push_res(4, lit, 0);
    main_run(1'b0, 1'b0);

    // Abort during the last WRITE suppresses done.
    push_res(4, lit, 0);
    main_start(1'b0);
    main_wait_results(m_seen_res + 3);
    repeat (4) @(posedge clk);
    #1;
    main_abort_now();

    // Asynchronous reset in the middle of ISSUE.
    push_res(4, lit, 0);
    main_start(1'b0);
    @(posedge clk); #1;
    check("main_a_addr_before_reset", m_a_addr, 1);
    check("main_b_addr_before_reset", m_b_addr, 6);
    resetn = 1'b0;
    #1;
    check("main_ctrl_in_reset", {m_busy, m_done, m_res_valid, m_a_addr, m_b_addr, m_res_addr}, 0);
    check("main_data_in_reset", m_res_data, 0);
    m_exp.delete();
    m_done_exp.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    lit = '{-5, -6, -7, -8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    load_main(-1, 0, 0, -1, 5, 6, 7, 8);
    push_res(4, lit, 0);
    main_run(1'b0, 1'b0);

    // Randomised 2x2x2 jobs with stray start pulses.
    for (int n = 0; n < 20; n++) begin
      for (int a = 0; a < 8; a++) m_mem[a] = rand_operand();
      ref_matmul(2, 2, 2, m_mem, res);
      push_res(4, res, 0);
      main_run(1'b0, 1'b0);
    end

    // 3x2x1 directed, then random.
    t_mem[0] = 1; t_mem[1] = 1; t_mem[2] = 2; t_mem[3] = 2; t_mem[4] = 3; t_mem[5] = 3;
    t_mem[6] = 4; t_mem[7] = 5;
    lit = '{9, 18, 27, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    push_res(3, lit, 1);
    tall_run();
    for (int n = 0; n < 5; n++) begin
      for (int a = 0; a < 8; a++) t_mem[a] = rand_operand();
      ref_matmul(3, 2, 1, t_mem, res);
      push_res(3, res, 1);
      tall_run();
    end

    // 1x1x1 overflow case, then random operands.
    u_mem[0] = 32'sh7FFFFFFF;
    u_mem[1] = 2;
`ifdef MATMUL_SATURATE_EN
    lit[0] = 32'sh7FFFFFFF;
`else
    lit[0] = 32'shFFFFFFFE;
`endif
    push_res(1, lit, 2);
    unit_run();
    for (int n = 0; n < 8; n++) begin
      u_mem[0] = rand_operand();
      u_mem[1] = rand_operand();
      ref_matmul(1, 1, 1, u_mem, res);
      push_res(1, res, 2);
      unit_run();
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
